// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard controller.
//   hz_state_t  - controller FSM state (IDLE, STALL)
//   ZERO_REG    - architectural zero register index ($zero)
//   DEF_REG_AW  - default register-address width
package hazard_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } hz_state_t;

    localparam int ZERO_REG   = 0;
    localparam int DEF_REG_AW = 5;

endpackage

// File: rtl/hazard_cmp.sv
// hazard_cmp: combinational load-use hazard detector.
// Flags a hazard when the EX-stage load writes a register that the ID-stage
// instruction reads (rs always, rt only when id_uses_rt).
// Ports:
//   id_rs, id_rt  - source register indices of the ID instruction
//   id_uses_rt    - ID instruction reads rt
//   ex_rt         - destination register of the EX instruction
//   ex_memread    - EX instruction is a load
//   hz            - load-use hazard present
// Parameters:
//   REG_AW        - register-address width
//   ZERO_SKIP     - 1: a load into the zero register never hazards
module hazard_cmp
    import hazard_pkg::*;
#(
    parameter int REG_AW    = DEF_REG_AW,
    parameter int ZERO_SKIP = 1
) (
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic              ex_memread,
    output logic              hz
);

    localparam logic [REG_AW-1:0] ZERO = REG_AW'(ZERO_REG);

    logic skip;
    logic match_rs;
    logic match_rt;

    assign skip     = (ZERO_SKIP != 0) && (ex_rt == ZERO);
    assign match_rs = (ex_rt == id_rs);
    assign match_rt = id_uses_rt && (ex_rt == id_rt);
    assign hz       = ex_memread && !skip && (match_rs || match_rt);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the pipelined MIPS core.
// Inserts LOAD_LAT bubble cycles per load-use hazard, freezes the front end
// while data memory is busy and, with HAZARD_BRANCH_FLUSH_EN defined,
// flushes IF/ID on a taken branch (otherwise branch_taken is ignored and
// ifid_flush is tied low).
//
// Ports:
//   clk, rst_n     - clock, synchronous active-low reset
//   id_rs, id_rt   - ID-stage source registers; id_uses_rt qualifies rt
//   ex_rt          - EX-stage destination; ex_memread marks a load
//   mem_stall      - data memory busy, freeze everything
//   branch_taken   - taken branch resolved in EX
//   pc_write, ifid_write, idex_write - pipeline write enables
//   ctrl_idex_mux  - 1 pass ID control, 0 insert bubble
//   ifid_flush     - clear IF/ID to NOP
//   stall_busy     - FSM in STALL
//   stall_cycles   - saturating count of load-use bubble cycles
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | normal flow; a hazard here produces the first bubble
// STALL | remaining bubbles; cnt holds bubbles still to go incl. this one
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW    = DEF_REG_AW,
    parameter int LOAD_LAT  = 1,
    parameter int ZERO_SKIP = 1,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic              ex_memread,
    input  logic              mem_stall,
    input  logic              branch_taken,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              idex_write,
    output logic              ctrl_idex_mux,
    output logic              ifid_flush,
    output logic              stall_busy,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam int              CW       = $clog2(LOAD_LAT + 1);
    localparam logic [CW-1:0]   CNT_INIT = CW'(LOAD_LAT - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

    hz_state_t          state, state_nxt;
    logic [CW-1:0]      cnt, cnt_nxt;
    logic [CNT_W-1:0]   stall_cycles_nxt;
    logic               hz;
    logic               bubble;

`ifndef HAZARD_BRANCH_FLUSH_EN
    logic unused_branch_taken;
    assign unused_branch_taken = branch_taken;
`endif

    hazard_cmp #(
        .REG_AW    (REG_AW),
        .ZERO_SKIP (ZERO_SKIP)
    ) u_cmp (
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rt (id_uses_rt),
        .ex_rt      (ex_rt),
        .ex_memread (ex_memread),
        .hz         (hz)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            stall_cycles <= '0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            stall_cycles <= stall_cycles_nxt;
        end
    end

    always_comb begin
        pc_write      = 1'b1;
        ifid_write    = 1'b1;
        idex_write    = 1'b1;
        ctrl_idex_mux = 1'b1;
        ifid_flush    = 1'b0;
        state_nxt     = state;
        cnt_nxt       = cnt;
        bubble        = 1'b0;

        if (!rst_n) begin
            pc_write      = 1'b0;
            ifid_write    = 1'b0;
            idex_write    = 1'b0;
            ctrl_idex_mux = 1'b0;
        end else if (mem_stall) begin
            // Full freeze: control passes through so the held ID/EX entry
            // is not corrupted; FSM and statistics hold.
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_write = 1'b0;
`ifdef HAZARD_BRANCH_FLUSH_EN
        end else if (branch_taken) begin
            // Younger instructions are discarded, so any pending stall is moot.
            ifid_flush    = 1'b1;
            ctrl_idex_mux = 1'b0;
            state_nxt     = IDLE;
            cnt_nxt       = '0;
`endif
        end else if (state == STALL) begin
            bubble = 1'b1;
            if (cnt == CNT_ONE) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end else begin
                cnt_nxt = cnt - CNT_ONE;
            end
        end else if (hz) begin
            bubble = 1'b1;
            if (LOAD_LAT > 1) begin
                state_nxt = STALL;
                cnt_nxt   = CNT_INIT;
            end
        end

        if (bubble) begin
            pc_write      = 1'b0;
            ifid_write    = 1'b0;
            ctrl_idex_mux = 1'b0;
        end

        stall_cycles_nxt = stall_cycles;
        if (bubble && (stall_cycles != '1))
            stall_cycles_nxt = stall_cycles + CNT_W'(1);
    end

    assign stall_busy = (state == STALL);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl. Three instances with different
// parameters share one stimulus stream; a behavioural model predicts each
// cycle's outputs, pushes them into a queue, and a negedge monitor compares.
module tb_hazard_ctrl;

`ifdef HAZARD_BRANCH_FLUSH_EN
    localparam bit BR_EN = 1'b1;
`else
    localparam bit BR_EN = 1'b0;
`endif

    localparam int N = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
    logic       id_uses_rt = 1'b0, ex_memread = 1'b0;
    logic       mem_stall = 1'b0, branch_taken = 1'b0;

    always #5 clk = ~clk;

    logic [5:0]  flags [N];
    logic [15:0] sc16;
    logic [1:0]  sc2;
    logic [3:0]  sc4;

    hazard_ctrl #(.REG_AW(5), .LOAD_LAT(3), .ZERO_SKIP(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_rt(ex_rt), .ex_memread(ex_memread),
        .mem_stall(mem_stall), .branch_taken(branch_taken),
        .pc_write(flags[0][5]), .ifid_write(flags[0][4]), .idex_write(flags[0][3]),
        .ctrl_idex_mux(flags[0][2]), .ifid_flush(flags[0][1]), .stall_busy(flags[0][0]),
        .stall_cycles(sc16));

    hazard_ctrl #(.REG_AW(5), .LOAD_LAT(1), .ZERO_SKIP(0), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_rt(ex_rt), .ex_memread(ex_memread),
        .mem_stall(mem_stall), .branch_taken(branch_taken),
        .pc_write(flags[1][5]), .ifid_write(flags[1][4]), .idex_write(flags[1][3]),
        .ctrl_idex_mux(flags[1][2]), .ifid_flush(flags[1][1]), .stall_busy(flags[1][0]),
        .stall_cycles(sc2));

    hazard_ctrl #(.REG_AW(5), .LOAD_LAT(15), .ZERO_SKIP(1), .CNT_W(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_rt(ex_rt), .ex_memread(ex_memread),
        .mem_stall(mem_stall), .branch_taken(branch_taken),
        .pc_write(flags[2][5]), .ifid_write(flags[2][4]), .idex_write(flags[2][3]),
        .ctrl_idex_mux(flags[2][2]), .ifid_flush(flags[2][1]), .stall_busy(flags[2][0]),
        .stall_cycles(sc4));

    function automatic int lat_of(int i);
        return (i == 0) ? 3 : (i == 1) ? 1 : 15;
    endfunction
    function automatic int zs_of(int i);
        return (i == 1) ? 0 : 1;
    endfunction
    function automatic int max_of(int i);
        return (i == 0) ? 65535 : (i == 1) ? 3 : 15;
    endfunction

    typedef struct packed {
        logic [N-1:0][5:0]  fl;
        logic [N-1:0][15:0] sc;
    } exp_t;

    exp_t exp_q[$];
    int   left [N];     // bubbles still owed after the current one
    int   stat [N];
    bit   known = 1'b0; // model state is defined only after a reset edge
    int   checks = 0;
    int   failures = 0;
    bit   stim_done = 1'b0;

    task automatic drive(input bit rst, input int rs, input int rt, input bit uses,
                         input int ert, input bit mr, input bit ms, input bit br);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rst; id_rs = 5'(rs); id_rt = 5'(rt); id_uses_rt = uses;
        ex_rt = 5'(ert); ex_memread = mr; mem_stall = ms; branch_taken = br;
        e = '0;
        for (int i = 0; i < N; i++) begin
            bit hz, busy;
            busy = (left[i] > 0);
            hz = mr && !(zs_of(i) != 0 && ert == 0) && (ert == rs || (uses && ert == rt));
            e.sc[i] = 16'(stat[i]);
            if (!rst) begin
                e.fl[i] = {5'b00000, busy};
                left[i] = 0; stat[i] = 0;
            end else if (ms) begin
                e.fl[i] = {5'b00010, busy};
            end else if (BR_EN && br) begin
                e.fl[i] = {5'b11101, busy};
                left[i] = 0;
            end else if (busy || hz) begin
                e.fl[i] = {5'b00100, busy};
                if (stat[i] < max_of(i)) stat[i]++;
                left[i] = busy ? left[i] - 1 : lat_of(i) - 1;
            end else begin
                e.fl[i] = {5'b11110, busy};
            end
        end
        if (known) exp_q.push_back(e);
        if (!rst) known = 1'b1;
    endtask

    // Monitor: outputs are valid every cycle; compare mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                logic [N-1:0][15:0] act_sc;
                e = exp_q.pop_front();
                act_sc[0] = sc16;
                act_sc[1] = {14'b0, sc2};
                act_sc[2] = {12'b0, sc4};
                for (int i = 0; i < N; i++) begin
                    checks++;
                    if (flags[i] !== e.fl[i]) begin
                        failures++;
                        $display("FAIL flags dut%0d t=%0t actual=%b required=%b (pc,ifid,idex,mux,flush,busy)",
                                 i, $time, flags[i], e.fl[i]);
                    end
                    checks++;
                    if (act_sc[i] !== e.sc[i]) begin
                        failures++;
                        $display("FAIL stall_cycles dut%0d t=%0t actual=%0d required=%0d",
                                 i, $time, act_sc[i], e.sc[i]);
                    end
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) begin left[i] = 0; stat[i] = 0; end
        repeat (3) drive(0, 0, 0, 0, 0, 0, 0, 0);
        // basic load-use on rs
        drive(1, 8, 1, 0, 8, 1, 0, 0);
        repeat (3) drive(1, 2, 3, 0, 4, 0, 0, 0);
        // rt hazard with and without id_uses_rt
        drive(1, 1, 9, 1, 9, 1, 0, 0);
        repeat (2) drive(1, 1, 9, 1, 9, 1, 0, 0);
        drive(1, 1, 9, 0, 9, 1, 0, 0);
        // zero register load
        drive(1, 0, 0, 0, 0, 1, 0, 0);
        drive(1, 2, 3, 0, 4, 0, 0, 0);
        // freeze during second bubble
        drive(1, 8, 0, 0, 8, 1, 0, 0);
        drive(1, 8, 0, 0, 8, 1, 1, 0);
        drive(1, 8, 0, 0, 8, 1, 1, 0);
        repeat (3) drive(1, 2, 3, 0, 4, 0, 0, 0);
        // branch during first bubble
        drive(1, 8, 0, 0, 8, 1, 0, 1);
        repeat (3) drive(1, 2, 3, 0, 4, 0, 0, 0);
        // reset mid-stall
        drive(1, 8, 0, 0, 8, 1, 0, 0);
        drive(0, 8, 0, 0, 8, 1, 0, 0);
        drive(1, 2, 3, 0, 4, 0, 0, 0);
        // saturation: repeated isolated hazards
        repeat (5) begin
            drive(1, 5, 0, 0, 5, 1, 0, 0);
            drive(1, 2, 3, 0, 4, 0, 0, 0);
        end
        // random traffic over a small register set to provoke frequent hazards
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom_range(99) >= 2),
                  int'($urandom_range(3)), int'($urandom_range(3)), 1'($urandom_range(1)),
                  int'($urandom_range(3)), ($urandom_range(99) < 50),
                  ($urandom_range(99) < 15), ($urandom_range(99) < 8));
        end
        stim_done = 1'b1;
        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL queue_drain actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
